// File: rtl/motor_pkg.sv
// Shared types and defaults for the H-bridge motor controller.
// Optional soft-start ramp is enabled by defining MOTOR_SOFTSTART_EN.
package motor_pkg;

    localparam int MOTOR_NCH    = 2;
    localparam int MOTOR_PWM_W  = 8;
    localparam int MOTOR_DT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEADTIME = 2'd1,
        DRIVE    = 2'd2,
        BRAKE    = 2'd3
    } motor_state_e;

    // Leg pattern for one bridge: DRIVE alternates drive/recirculate by pwm,
    // BRAKE shorts both low-sides, everything else coasts.
    function automatic logic [1:0] leg_drive(motor_state_e st, logic pwm, logic dir_q);
        logic [1:0] v;
        v = 2'b00;
        if (st == DRIVE)
            v = dir_q ? {pwm, ~pwm} : {~pwm, pwm};
        else if (st == BRAKE)
            v = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/motor_bridge_ctrl_if.sv
// Per-channel command/status bundle between the controller top and one bridge channel.
// Channel behaviour under MOTOR_SOFTSTART_EN does not change this bundle.
interface motor_bridge_ctrl_if #(
    parameter int PWM_W = motor_pkg::MOTOR_PWM_W
);
    logic [PWM_W-1:0] duty;
    logic             dir;
    logic             en;
    logic             brake;
    logic [1:0]       mt;
    logic             en_o;
    logic             active;

    modport master (output duty, dir, en, brake, input  mt, en_o, active);
    modport slave  (input  duty, dir, en, brake, output mt, en_o, active);
endinterface

// File: rtl/motor_bridge_ch.sv
// One H-bridge channel: state machine, dead-time counter, effective duty, registered leg drive.
// MOTOR_SOFTSTART_EN ramps duty_eff up by one step per PWM period.
module motor_bridge_ch
    import motor_pkg::*;
#(
    parameter int PWM_W  = MOTOR_PWM_W,
    parameter int DT_CYC = MOTOR_DT_CYC
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    input  logic [PWM_W-1:0]   i_cnt,
    input  logic               i_estop,
    motor_bridge_ctrl_if.slave ch
);
    localparam logic [7:0] DT_LOAD = 8'(DT_CYC);

    motor_state_e     r_state, w_state_nxt;
    logic             r_dir_q, w_dir_q_nxt;
    logic [7:0]       r_dt, w_dt_nxt;
    logic [PWM_W-1:0] r_duty_eff, w_duty_upd, w_duty_cur;
    logic             w_pwm;
    logic [1:0]       r_mt;
    logic             r_en_o, r_active;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state <= IDLE;
            r_dir_q <= 1'b0;
            r_dt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir_q <= w_dir_q_nxt;
            r_dt    <= w_dt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_q_nxt = r_dir_q;
        w_dt_nxt    = r_dt;
        if (i_estop || !ch.en) begin
            w_state_nxt = IDLE;
        end else if (ch.brake) begin
            w_state_nxt = BRAKE;
        end else begin
            case (r_state)
                IDLE, BRAKE: begin
                    w_state_nxt = DEADTIME;
                    w_dir_q_nxt = ch.dir;
                    w_dt_nxt    = DT_LOAD;
                end
                DEADTIME: begin
                    if (ch.dir != r_dir_q) begin
                        w_dir_q_nxt = ch.dir;
                        w_dt_nxt    = DT_LOAD;
                    end else begin
                        w_dt_nxt = r_dt - 8'd1;
                        // counter hits zero on this edge: gap has lasted DT_CYC cycles
                        if (r_dt == 8'd1)
                            w_state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (ch.dir != r_dir_q) begin
                        w_state_nxt = DEADTIME;
                        w_dir_q_nxt = ch.dir;
                        w_dt_nxt    = DT_LOAD;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef MOTOR_SOFTSTART_EN
    assign w_duty_upd = (ch.duty > r_duty_eff) ? r_duty_eff + PWM_W'(1) : ch.duty;
`else
    assign w_duty_upd = ch.duty;
`endif

    // The cnt==0 cycle already uses the freshly sampled duty so a period never mixes two values.
    assign w_duty_cur = (i_cnt == '0) ? w_duty_upd : r_duty_eff;
    assign w_pwm      = (i_cnt < w_duty_cur);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n)
            r_duty_eff <= '0;
`ifdef MOTOR_SOFTSTART_EN
        else if (w_state_nxt != DRIVE)
            r_duty_eff <= '0;
`endif
        else
            r_duty_eff <= w_duty_cur;
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_mt     <= 2'b00;
            r_en_o   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_mt     <= leg_drive(r_state, w_pwm, r_dir_q);
            r_en_o   <= (r_state == DRIVE) || (r_state == BRAKE);
            r_active <= (r_state == DRIVE);
        end
    end

    assign ch.mt     = r_mt;
    assign ch.en_o   = r_en_o;
    assign ch.active = r_active;

endmodule

// File: rtl/motor_bridge_ctrl.sv
// Multi-channel H-bridge controller: shared PWM counter plus NCH dead-time protected channels.
// Define MOTOR_SOFTSTART_EN to enable the per-channel duty ramp.
module motor_bridge_ctrl
    import motor_pkg::*;
#(
    parameter int NCH    = MOTOR_NCH,
    parameter int PWM_W  = MOTOR_PWM_W,
    parameter int DT_CYC = MOTOR_DT_CYC
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys_n,
    input  logic [NCH*PWM_W-1:0] duty,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       brake,
    input  logic                 estop,
    output logic [2*NCH-1:0]     mt,
    output logic [NCH-1:0]       en_o,
    output logic [NCH-1:0]       active
);
    // Period is 2^PWM_W-1 so a full-scale duty keeps the output on every cycle.
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PWM_W-1:0] r_cnt;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n)
            r_cnt <= '0;
        else if (r_cnt == CNT_LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + PWM_W'(1);
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        motor_bridge_ctrl_if #(.PWM_W(PWM_W)) ch_if ();

        assign ch_if.duty      = duty[g*PWM_W +: PWM_W];
        assign ch_if.dir       = dir[g];
        assign ch_if.en        = en[g];
        assign ch_if.brake     = brake[g];
        assign mt[2*g +: 2]    = ch_if.mt;
        assign en_o[g]         = ch_if.en_o;
        assign active[g]       = ch_if.active;

        motor_bridge_ch #(
            .PWM_W  (PWM_W),
            .DT_CYC (DT_CYC)
        ) u_ch (
            .clk_sys   (clk_sys),
            .rst_sys_n (rst_sys_n),
            .i_cnt     (r_cnt),
            .i_estop   (estop),
            .ch        (ch_if.slave)
        );
    end

endmodule

// File: doc/motor_bridge_ctrl.md
MOTOR_BRIDGE_CTRL -- requirements
Module: motor_bridge_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2: number of H-bridge channels, range 1..8.
REQ-002 SHALL have parameter PWM_W, default 8: duty width; PWM period = 2^PWM_W-1 clk_sys cycles.
REQ-003 SHALL have parameter DT_CYC, default 16: dead-time length in clk_sys cycles, range 1..255.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk_sys  input  1  system clock, all logic rising-edge.
REQ-006 SHALL have port rst_sys_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port duty  input  NCH*PWM_W  per-channel target duty; channel i at [i*PWM_W +: PWM_W].
REQ-008 SHALL have port dir  input  NCH  per-channel direction request.
REQ-009 SHALL have port en  input  NCH  per-channel run enable.
REQ-010 SHALL have port brake  input  NCH  per-channel active-brake request.
REQ-011 SHALL have port estop  input  1  emergency stop, active-high, synchronous to clk_sys.
REQ-012 SHALL have port mt  output  2*NCH  bridge leg drive; channel i at [2i+1:2i].
REQ-013 SHALL have port en_o  output  NCH  bridge enable per channel.
REQ-014 SHALL have port active  output  NCH  high while channel is in DRIVE.

Function
REQ-015 SHALL run one shared PWM counter 0..2^PWM_W-2, wrapping to 0; pwm_i = (cnt < duty_eff_i).
REQ-016 SHALL latch duty_eff only when cnt==0, so no mid-period duty change; duty=2^PWM_W-1 gives 100%, duty=0 gives 0%.
REQ-017 SHALL implement per-channel FSM with states IDLE, DEADTIME, DRIVE, BRAKE.
REQ-018 SHALL use priority estop > en=0 > brake > dir change for transitions evaluated each cycle.
REQ-019 SHALL go IDLE->DEADTIME on en=1 and brake=0, latching dir into dir_q and loading the dead-time counter with DT_CYC.
REQ-020 SHALL go DEADTIME->DRIVE when the dead-time counter reaches 0, i.e. exactly DT_CYC cycles after entry.
REQ-021 SHALL go DRIVE->DEADTIME when dir!=dir_q, latching the new dir; a dir change during DEADTIME relatches dir and reloads DT_CYC.
REQ-022 SHALL go from any state to BRAKE on en=1 and brake=1, and BRAKE->DEADTIME on brake=0 with en=1.
REQ-023 SHALL go from any state to IDLE on en=0 or estop=1, within the same clock edge.
REQ-024 SHALL hold all channels IDLE while estop=1; after estop falls, channels with en=1 SHALL pass through DEADTIME.
REQ-025 SHALL drive registered outputs, one cycle after state/pwm: IDLE and DEADTIME give mt=00 and en_o=0; BRAKE gives mt=11 and en_o=1.
REQ-026 SHALL in DRIVE give en_o=1, mt={~pwm,pwm} for dir_q=0 and mt={pwm,~pwm} for dir_q=1.
REQ-027 SHALL never let mt switch directly between the 01 and 10 phase patterns of opposite directions without at least DT_CYC cycles of 00.

Reset
REQ-028 SHALL on rst_sys_n=0 asynchronously clear: cnt=0, all FSMs=IDLE, dir_q=0, duty_eff=0, mt=0, en_o=0, active=0.
REQ-029 SHALL on reset mid-DRIVE force coast (mt=00) immediately, without waiting for a clock edge.

Configuration
REQ-030 SHALL support macro MOTOR_SOFTSTART_EN: when defined, duty_eff SHALL rise by 1 per PWM period toward the target, while decreases apply immediately at cnt==0; duty_eff SHALL reset to 0 on entry to DEADTIME, IDLE or BRAKE.
REQ-031 SHALL without MOTOR_SOFTSTART_EN load duty_eff directly from the target at each cnt==0.

Structure
REQ-032 SHALL place the state enum (IDLE, DEADTIME, DRIVE, BRAKE) and the default PWM_W/DT_CYC constants in package motor_pkg.
REQ-033 SHALL implement one channel (FSM, dead-time counter, duty_eff, output regs) as sub-module motor_bridge_ch, instantiated NCH times by a generate loop; the PWM counter SHALL stay in the top module.

Verification
REQ-034 SHALL cover: NCH=2, PWM_W=8, duty0=64, en0=1, dir0=0 -> 16 cycles of mt[1:0]=00, then a 01 pattern high for 64 of every 255 cycles, with en_o[0]=1.
REQ-035 SHALL cover: in DRIVE, toggle dir0 -> mt[1:0]=00 for exactly 16 cycles, then the inverted pattern; active[0]=0 during the gap.
REQ-036 SHALL cover: brake1=1 with en1=1 -> mt[3:2]=11 and en_o[1]=1 on the next cycle; release brake -> 16 cycles of 00, then DRIVE.
REQ-037 SHALL cover: estop=1 while both channels are in DRIVE -> mt=0000 and en_o=00 the next cycle; estop=0 -> DEADTIME, then DRIVE.
REQ-038 SHALL cover: duty=255 gives a constant 01 pattern; duty=0 gives constant 10 for dir=0; a duty change mid-period takes effect only at cnt==0.
REQ-039 SHALL cover, with MOTOR_SOFTSTART_EN: target 10 from start -> duty_eff increments 1, 2, ... 10 over 10 PWM periods; target 3 afterwards -> 3 at the next period.
